// File: rtl/store_issue_pkg.sv
// Shared MEM-stage memory-access definitions.
//
// Holds the store opcode encodings, the data-memory and timer address map,
// the bus request record carried from the pipeline to the system bridge, and
// small address-window helpers used by the store range check.
package store_issue_pkg;

    // Store opcodes. Encodings with bit 2 set are not listed here and are
    // treated as ST_NONE by the lane aligner.
    typedef enum logic [2:0] {
        ST_NONE = 3'b000,
        ST_SW   = 3'b001,
        ST_SH   = 3'b010,
        ST_SB   = 3'b011
    } st_op_e;

    // Address map.
    localparam logic [31:0] DM_LO        = 32'h0000_0000;
    localparam logic [31:0] DM_HI        = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE     = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE     = 32'h0000_7F10;
    localparam logic [31:0] TC_LAST_OFF  = 32'h0000_000B;
    // Timer COUNT register offset; it is read-only.
    localparam logic [3:0]  TC_COUNT_OFF = 4'h8;

    // One word-aligned write as presented to the bridge.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } bus_req_t;

    // Unsigned subtraction wraps for addresses below the base, so a single
    // compare covers both ends of the window.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] last_off);
        return (addr - base) <= last_off;
    endfunction

    function automatic logic in_dm(input logic [31:0] addr);
        return in_window(addr, DM_LO, DM_HI - DM_LO);
    endfunction

    function automatic logic in_timer(input logic [31:0] addr);
        return in_window(addr, TC0_BASE, TC_LAST_OFF) ||
               in_window(addr, TC1_BASE, TC_LAST_OFF);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Store lane aligner (purely combinational).
//
// Converts a store opcode, the low address bits and the unaligned rt value
// into lane-replicated write data, byte enables and a misalignment flag.
//
// Ports:
//   op          in   3  store opcode (1xx behaves as ST_NONE)
//   addr_lo     in   2  byte offset within the word
//   data        in  32  rt value, low bytes significant
//   byteen      out  4  byte enables (0000 for ST_NONE)
//   wdata       out 32  lane-replicated write data
//   misalign    out  1  sw not word aligned, or sh not halfword aligned
//   is_store    out  1  op is sw/sh/sb
//   is_sub_word out  1  op is sh/sb
module store_lane_align
    import store_issue_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic        is_store,
    output logic        is_sub_word
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        byteen      = 4'b0000;
        wdata       = 32'h0000_0000;
        misalign    = 1'b0;
        is_store    = 1'b0;
        is_sub_word = 1'b0;
        case (op)
            ST_SW: begin
                is_store = 1'b1;
                wdata    = data;
                byteen   = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            ST_SH: begin
                is_store    = 1'b1;
                is_sub_word = 1'b1;
                wdata       = {2{data[15:0]}};
                byteen      = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign    = addr_lo[0];
            end
            ST_SB: begin
                is_store    = 1'b1;
                is_sub_word = 1'b1;
                wdata       = {4{data[7:0]}};
                byteen      = 4'b0001 << addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_issue.sv
// MEM-stage store issue unit.
//
// Accepts one store per req handshake, rejects misaligned or out-of-map
// stores with a one-cycle AdES pulse, and otherwise registers a word-aligned
// write and holds it on the bridge bus until bus_ready, abandoning it with a
// one-cycle exc_bus pulse after TIMEOUT unanswered cycles.
//
// Ports:
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous active-low reset
//   req_valid   in   1  pipeline presents a store
//   req_ready   out  1  unit can accept this cycle
//   req_addr    in  32  byte address
//   req_data    in  32  rt value, low bytes significant
//   req_op      in   3  store opcode
//   exc_ades    out  1  one-cycle store address exception
//   exc_bus     out  1  one-cycle bus timeout
//   bus_valid   out  1  write request valid
//   bus_ready   in   1  bridge accepts write
//   bus_addr    out 32  word-aligned address
//   bus_wdata   out 32  lane-replicated data
//   bus_byteen  out  4  byte enables
module store_issue
    import store_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15  // 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_op,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen
);

    typedef enum logic {IDLE, ISSUE} state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] WAIT_SAT  = 8'(TIMEOUT);

    state_e     state;
    logic [7:0] wait_cnt;
    bus_req_t   bus_q;

    logic [3:0]  lane_byteen;
    logic [31:0] lane_wdata;
    logic        lane_misalign;
    logic        is_store;
    logic        is_sub_word;

    logic accept;
    logic timer_hit;
    logic count_hit;
    logic fault;
    logic good;
    bus_req_t next_req;

    store_lane_align u_lane (
        .op          (req_op),
        .addr_lo     (req_addr[1:0]),
        .data        (req_data),
        .byteen      (lane_byteen),
        .wdata       (lane_wdata),
        .misalign    (lane_misalign),
        .is_store    (is_store),
        .is_sub_word (is_sub_word)
    );

    // Ready only looks at state and bus_ready, never at req_*.
    assign req_ready = (state == IDLE) || (state == ISSUE && bus_ready);
    assign accept    = req_valid && req_ready;

    assign timer_hit = in_timer(req_addr);
    assign count_hit = timer_hit && (req_addr[3:0] >= TC_COUNT_OFF);
    assign fault     = is_store && (lane_misalign ||
                                    !(in_dm(req_addr) || timer_hit) ||
                                    (timer_hit && is_sub_word) ||
                                    count_hit);
    assign good      = is_store && !fault;

    assign next_req = '{addr:   {req_addr[31:2], 2'b00},
                        wdata:  lane_wdata,
                        byteen: lane_byteen};

    assign bus_addr   = bus_q.addr;
    assign bus_wdata  = bus_q.wdata;
    assign bus_byteen = bus_q.byteen;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            bus_q     <= '0;
            bus_valid <= 1'b0;
            exc_ades  <= 1'b0;
            exc_bus   <= 1'b0;
        end else begin
            exc_ades <= accept && fault;
            exc_bus  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && good) begin
                        bus_q     <= next_req;
                        bus_valid <= 1'b1;
                        wait_cnt  <= 8'd0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus_ready) begin
                        // Completion; a good store in the same cycle chains on.
                        if (accept && good) begin
                            bus_q    <= next_req;
                            wait_cnt <= 8'd0;
                        end else begin
                            bus_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Last unanswered cycle: drop the write.
                        bus_valid <= 1'b0;
                        exc_bus   <= 1'b1;
                        wait_cnt  <= WAIT_SAT;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_issue.sv
// Directed self-checking bench for store_issue (TIMEOUT overridden to 4).
module tb_store_issue;
    import store_issue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_op;
    logic        exc_ades;
    logic        exc_bus;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;

    int n_checks = 0;
    int n_fail   = 0;

    store_issue #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_op     (req_op),
        .exc_ades   (exc_ades),
        .exc_bus    (exc_bus),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_byteen (bus_byteen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
        req_valid = v;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " bus_valid"},  32'(bus_valid),  32'd0);
        check({tag, " bus_addr"},   bus_addr,        32'd0);
        check({tag, " bus_wdata"},  bus_wdata,       32'd0);
        check({tag, " bus_byteen"}, 32'(bus_byteen), 32'd0);
        check({tag, " exc_ades"},   32'(exc_ades),   32'd0);
        check({tag, " exc_bus"},    32'(exc_bus),    32'd0);
    endtask

    // Faulting stores: op, address.
    localparam int N_FAULT = 7;
    logic [2:0]  f_op   [N_FAULT] = '{ST_SW, ST_SB, ST_SW, ST_SW, ST_SH, ST_SB, ST_SW};
    logic [31:0] f_addr [N_FAULT] = '{32'h0000_0006, 32'h0000_7F04, 32'h0000_7F18,
                                      32'h0000_3000, 32'h0000_0101, 32'h0000_7F1B,
                                      32'h0000_7F08};

    initial begin
        reset     = 1'b0;
        bus_ready = 1'b1;
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);

        // sb to byte 3.
        drive(1'b1, ST_SB, 32'h0000_1003, 32'h1234_56AB);
        tick();
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        check("sb bus_valid",  32'(bus_valid),  32'd1);
        check("sb bus_addr",   bus_addr,        32'h0000_1000);
        check("sb bus_byteen", 32'(bus_byteen), 32'h8);
        check("sb bus_wdata",  bus_wdata,       32'hABAB_ABAB);
        check("sb exc_ades",   32'(exc_ades),   32'd0);
        tick();
        check("sb done bus_valid", 32'(bus_valid), 32'd0);

        // sh to upper half.
        drive(1'b1, ST_SH, 32'h0000_0002, 32'hFFFF_BEEF);
        tick();
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        check("sh bus_addr",   bus_addr,        32'h0000_0000);
        check("sh bus_byteen", 32'(bus_byteen), 32'hC);
        check("sh bus_wdata",  bus_wdata,       32'hBEEF_BEEF);
        tick();

        // Address exceptions.
        for (int i = 0; i < N_FAULT; i++) begin
            drive(1'b1, f_op[i], f_addr[i], 32'h5555_AAAA);
            tick();
            drive(1'b0, ST_NONE, 32'd0, 32'd0);
            check($sformatf("ades[%0d] exc_ades", i),  32'(exc_ades),  32'd1);
            check($sformatf("ades[%0d] bus_valid", i), 32'(bus_valid), 32'd0);
            tick();
            check($sformatf("ades[%0d] pulse end", i), 32'(exc_ades), 32'd0);
        end

        // ST_NONE and 1xx are accepted with no effect.
        drive(1'b1, 3'b101, 32'h0000_0006, 32'h1);
        tick();
        check("none bus_valid", 32'(bus_valid), 32'd0);
        check("none exc_ades",  32'(exc_ades),  32'd0);
        drive(1'b0, ST_NONE, 32'd0, 32'd0);

        // Legal timer word and last DM word.
        drive(1'b1, ST_SW, 32'h0000_7F14, 32'hCAFE_F00D);
        tick();
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        check("tc1 bus_valid",  32'(bus_valid),  32'd1);
        check("tc1 bus_addr",   bus_addr,        32'h0000_7F14);
        check("tc1 bus_byteen", 32'(bus_byteen), 32'hF);
        check("tc1 bus_wdata",  bus_wdata,       32'hCAFE_F00D);
        check("tc1 exc_ades",   32'(exc_ades),   32'd0);
        tick();
        drive(1'b1, ST_SW, 32'h0000_2FFC, 32'h0BAD_CAFE);
        tick();
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        check("dm top bus_valid", 32'(bus_valid), 32'd1);
        check("dm top bus_addr",  bus_addr,       32'h0000_2FFC);
        tick();

        // Timeout with bus_ready held low.
        bus_ready = 1'b0;
        drive(1'b1, ST_SW, 32'h0000_0100, 32'h0000_0011);
        tick();
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("to cyc%0d bus_valid", c), 32'(bus_valid), 32'd1);
            check($sformatf("to cyc%0d bus_addr", c),  bus_addr,       32'h0000_0100);
            check($sformatf("to cyc%0d bus_wdata", c), bus_wdata,      32'h0000_0011);
            check($sformatf("to cyc%0d req_ready", c), 32'(req_ready), 32'd0);
            check($sformatf("to cyc%0d exc_bus", c),   32'(exc_bus),   32'd0);
            tick();
        end
        check("to bus_valid low", 32'(bus_valid), 32'd0);
        check("to exc_bus",       32'(exc_bus),   32'd1);
        check("to req_ready",     32'(req_ready), 32'd1);
        tick();
        check("to exc_bus end",   32'(exc_bus),   32'd0);

        // Back-to-back stores with the bridge always ready.
        bus_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, ST_SW, 32'h0000_0010 + 32'(4 * k), 32'hA000_0000 + 32'(k));
            tick();
            check($sformatf("b2b[%0d] bus_valid", k), 32'(bus_valid), 32'd1);
            check($sformatf("b2b[%0d] bus_addr", k),  bus_addr,       32'h0000_0010 + 32'(4 * k));
            check($sformatf("b2b[%0d] bus_wdata", k), bus_wdata,      32'hA000_0000 + 32'(k));
        end
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        tick();
        check("b2b idle bus_valid", 32'(bus_valid), 32'd0);

        // Reset during ISSUE.
        bus_ready = 1'b0;
        drive(1'b1, ST_SW, 32'h0000_0020, 32'h1111_2222);
        tick();
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        check("rst-issue bus_valid", 32'(bus_valid), 32'd1);
        reset = 1'b0;
        tick();
        check_reset_outputs("rst-issue");
        reset     = 1'b1;
        bus_ready = 1'b1;
        #1;
        check("rst-issue req_ready", 32'(req_ready), 32'd1);
        drive(1'b1, ST_SW, 32'h0000_0024, 32'h3333_4444);
        tick();
        drive(1'b0, ST_NONE, 32'd0, 32'd0);
        check("post-rst bus_valid", 32'(bus_valid), 32'd1);
        check("post-rst bus_addr",  bus_addr,       32'h0000_0024);
        check("post-rst bus_wdata", bus_wdata,      32'h3333_4444);
        tick();
        check("post-rst idle",      32'(bus_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
